// File: rtl/pbkdf2_final_loader.sv
// ============================================================================
// Module   : pbkdf2_final_loader
// Brief    : Builds the 1696-bit header||X||INT_BLOCK message for the final
//            PBKDF2 HMAC-SHA256 pass of scrypt and holds the resulting hash.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pbkdf2_final_loader #(
    parameter logic [31:0] INT_BLOCK = 32'h00000001,
    parameter int          NUM_WORDS = 32
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [639:0]    header,
    input  logic            header_valid,
    input  logic [31:0]     word_in,
    input  logic            word_valid,
    output logic            word_ready,
    output logic [1695:0]   data,
    output logic            enable,
    input  logic [255:0]    hash_in,
    input  logic            hash_done,
    output logic [255:0]    result,
    output logic            result_valid,
    input  logic            result_ack,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FIRE = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [4:0] c_LAST_SLOT = 5'(NUM_WORDS - 1);

    state_t         r_state;
    state_t         w_next;
    logic [639:0]   r_header;
    logic [31:0]    r_xw [0:31];
    logic [4:0]     r_count;
    logic           r_word_ready;
    logic           r_enable;
    logic           r_result_valid;
    logic           r_busy;
    logic [255:0]   r_result;
    logic           w_accept;

    // r_word_ready is high exactly while in LOAD, so it doubles as the state qualifier.
    assign w_accept = r_word_ready && word_valid;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (header_valid) w_next = S_LOAD;
            S_LOAD: if (w_accept && (r_count == c_LAST_SLOT)) w_next = S_FIRE;
            S_FIRE: w_next = S_WAIT;
            S_WAIT: if (hash_done) w_next = S_DONE;
            S_DONE: if (result_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are registered
    // and line up with the state they describe.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_header       <= '0;
            r_count        <= '0;
            r_word_ready   <= 1'b0;
            r_enable       <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_result       <= '0;
            for (int k = 0; k < 32; k++) begin
                r_xw[k] <= '0;
            end
        end else begin
            r_word_ready   <= (w_next == S_LOAD);
            r_enable       <= (w_next == S_FIRE);
            r_result_valid <= (w_next == S_DONE);
            r_busy         <= (w_next != S_IDLE);

            if ((r_state == S_IDLE) && header_valid) begin
                r_header <= header;
                r_count  <= '0;
            end

            if (w_accept) begin
                r_xw[r_count] <= word_in;
                r_count       <= r_count + 5'd1;
            end

            if ((r_state == S_WAIT) && hash_done) begin
                r_result <= hash_in;
            end
        end
    end

    assign data[1695:1056] = r_header;
    assign data[31:0]      = INT_BLOCK;

    // Slot 0 is the most significant word of the X field.
    genvar g;
    generate
        for (g = 0; g < 32; g++) begin : g_xpack
            assign data[1055 - 32*g -: 32] = r_xw[g];
        end
    endgenerate

    assign word_ready   = r_word_ready;
    assign enable       = r_enable;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pbkdf2_final_loader.sv
// ============================================================================
// Module   : tb_pbkdf2_final_loader
// Brief    : Self-checking bench for pbkdf2_final_loader with a job-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pbkdf2_final_loader;

    localparam logic [31:0] c_INT_BLOCK = 32'h00000001;

    logic            clk = 1'b0;
    logic            n_rst;
    logic [639:0]    header;
    logic            header_valid;
    logic [31:0]     word_in;
    logic            word_valid;
    logic            word_ready;
    logic [1695:0]   data;
    logic            enable;
    logic [255:0]    hash_in;
    logic            hash_done;
    logic [255:0]    result;
    logic            result_valid;
    logic            result_ack;
    logic            busy;

    int              checks   = 0;
    int              failures = 0;
    logic [31:0]     words [32];
    logic [255:0]    exp_result;

    pbkdf2_final_loader #(
        .INT_BLOCK (c_INT_BLOCK),
        .NUM_WORDS (32)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .header       (header),
        .header_valid (header_valid),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .data         (data),
        .enable       (enable),
        .hash_in      (hash_in),
        .hash_done    (hash_done),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [639:0] hdr, input logic [1023:0] x);
        check({tag, "_hdr"}, data[1695:1056], hdr);
        check({tag, "_xhi"}, 640'(data[1055:544]), 640'(x[1023:512]));
        check({tag, "_xlo"}, 640'(data[543:32]), 640'(x[511:0]));
        check({tag, "_idx"}, 640'(data[31:0]), 640'(c_INT_BLOCK));
    endtask

    // Drives one job through the loader and checks it against the expected
    // message layout. mode: 0 back-to-back, 1 alternate, 2 random valid.
    // abort_at > 0 pulses reset after that many accepted words.
    task automatic run_job(input logic [639:0] hdr, input int mode, input int abort_at,
                           input int ack_delay, input logic [255:0] h);
        logic [1023:0] exp_x;
        logic [639:0]  other;
        logic          v;
        int            k;
        int            cyc;
        int            d;

        other = ~hdr;
        exp_x = '0;
        for (int i = 0; i < 32; i++) begin
            exp_x[1023 - 32*i -: 32] = words[i];
        end

        check("idle_ready", 640'(word_ready), 640'(0));
        check("idle_busy", 640'(busy), 640'(0));
        header       = hdr;
        header_valid = 1'b1;
        word_valid   = 1'b1;
        word_in      = 32'hBAD0BAD0;
        @(negedge clk);
        header_valid = 1'b0;
        word_valid   = 1'b0;
        check("load_busy", 640'(busy), 640'(1));

        k   = 0;
        cyc = 0;
        while (k < 32) begin
            check("load_ready", 640'(word_ready), 640'(1));
            check("load_en", 640'(enable), 640'(0));
            if (abort_at > 0 && k == abort_at) begin
                word_valid   = 1'b0;
                header_valid = 1'b0;
                hash_done    = 1'b0;
                n_rst        = 1'b1;
                @(negedge clk);
                n_rst      = 1'b0;
                exp_result = '0;
                check("abort_busy", 640'(busy), 640'(0));
                check("abort_ready", 640'(word_ready), 640'(0));
                check("abort_rv", 640'(result_valid), 640'(0));
                check("abort_res", 640'(result), 640'(0));
                check_data("abort", '0, '0);
                @(negedge clk);
                check("abort_en", 640'(enable), 640'(0));
                check("abort_rv2", 640'(result_valid), 640'(0));
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            word_valid   = v;
            word_in      = words[k];
            header_valid = 1'($urandom_range(0, 1));
            header       = other;
            hash_done    = 1'($urandom_range(0, 1));
            hash_in      = {8{$urandom}};
            @(negedge clk);
            cyc++;
            if (v) k++;
            if (cyc > 200) begin
                check("load_timeout", 640'(cyc), 640'(0));
                return;
            end
        end
        word_valid   = 1'b0;
        header_valid = 1'b0;

        check("fire_en", 640'(enable), 640'(1));
        check("fire_ready", 640'(word_ready), 640'(0));
        check("fire_rv", 640'(result_valid), 640'(0));
        check("fire_res", 640'(result), 640'(exp_result));
        check_data("fire", hdr, exp_x);
        hash_done = 1'b1;
        hash_in   = ~h;
        @(negedge clk);

        hash_done = 1'b0;
        d = $urandom_range(1, 4);
        for (int i = 0; i < d; i++) begin
            check("wait_en", 640'(enable), 640'(0));
            check("wait_rv", 640'(result_valid), 640'(0));
            check("wait_busy", 640'(busy), 640'(1));
            check_data("wait", hdr, exp_x);
            result_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        hash_done  = 1'b1;
        hash_in    = h;
        result_ack = (ack_delay == 0);
        @(negedge clk);
        hash_done  = 1'b0;
        hash_in    = '0;
        exp_result = h;

        for (int i = 0; i < ack_delay; i++) begin
            check("done_rv", 640'(result_valid), 640'(1));
            check("done_res", 640'(result), 640'(h));
            check("done_en", 640'(enable), 640'(0));
            @(negedge clk);
        end
        check("ack_rv", 640'(result_valid), 640'(1));
        check("ack_res", 640'(result), 640'(h));
        result_ack   = 1'b1;
        header_valid = 1'b1;
        header       = other;
        @(negedge clk);
        result_ack   = 1'b0;
        header_valid = 1'b0;
        check("post_busy", 640'(busy), 640'(0));
        check("post_rv", 640'(result_valid), 640'(0));
        check("post_res", 640'(result), 640'(h));
        check("post_ready", 640'(word_ready), 640'(0));
        @(negedge clk);
        check("post_ready2", 640'(word_ready), 640'(0));
        check("post_hdr", data[1695:1056], hdr);
    endtask

    initial begin
        n_rst        = 1'b1;
        header       = '0;
        header_valid = 1'b0;
        word_in      = '0;
        word_valid   = 1'b0;
        hash_in      = '0;
        hash_done    = 1'b0;
        result_ack   = 1'b0;
        exp_result   = '0;
        repeat (2) @(negedge clk);
        check("rst_en", 640'(enable), 640'(0));
        check("rst_ready", 640'(word_ready), 640'(0));
        check("rst_rv", 640'(result_valid), 640'(0));
        check("rst_busy", 640'(busy), 640'(0));
        check("rst_res", 640'(result), 640'(0));
        check_data("rst", '0, '0);
        n_rst = 1'b0;

        word_valid = 1'b1;
        word_in    = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        word_valid = 1'b0;
        check("idlew_ready", 640'(word_ready), 640'(0));
        check_data("idlew", '0, '0);

        for (int i = 0; i < 32; i++) words[i] = 32'(i);
        run_job({80{8'hA5}}, 0, 0, 10, {8{32'hDEADBEEF}});

        for (int i = 0; i < 32; i++) words[i] = $urandom;
        run_job({20{$urandom}}, 1, 0, 0, {8{$urandom}});

        for (int i = 0; i < 32; i++) words[i] = $urandom;
        run_job({20{$urandom}}, 2, 17, 0, '0);

        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 32; i++) words[i] = $urandom;
            run_job({20{$urandom}}, j % 3, 0, $urandom_range(0, 3), {8{$urandom}});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
